// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE between accesses, ACCESS for the
//                 single cycle in which the memory is driven).
//   req_id_t    : requester identity (CPU = port 0, maze engine = port 1).
//   NREQ        : number of requesters.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_ENG = 1'b1
    } req_id_t;

    localparam int NREQ = 2;

endpackage

// File: rtl/dmem_arb_if.sv
// -----------------------------------------------------------------------------
// dmem_arb_if
// Bundles the CPU and engine req/ack ports and the dmem-side bus.
// Parameters: Nloc (memory depth), Dbits (data width); AW = $clog2(Nloc).
//   cpu_req/cpu_wr/cpu_addr/cpu_writedata : CPU request (held until cpu_ack)
//   cpu_ack/cpu_readdata                  : CPU completion pulse and read data
//   eng_req/eng_wr/eng_addr/eng_writedata : engine request
//   eng_ack/eng_readdata                  : engine completion pulse and data
//   mem_wr/mem_addr/mem_writedata         : to dmem
//   mem_readdata                          : from dmem (asynchronous read)
// Modports: slave = arbiter view, master = requesters + memory view.
// -----------------------------------------------------------------------------
interface dmem_arb_if #(
    parameter int Nloc  = 64,
    parameter int Dbits = 32
);
    localparam int AW = $clog2(Nloc);

    logic             cpu_req;
    logic             cpu_wr;
    logic [AW-1:0]    cpu_addr;
    logic [Dbits-1:0] cpu_writedata;
    logic             cpu_ack;
    logic [Dbits-1:0] cpu_readdata;

    logic             eng_req;
    logic             eng_wr;
    logic [AW-1:0]    eng_addr;
    logic [Dbits-1:0] eng_writedata;
    logic             eng_ack;
    logic [Dbits-1:0] eng_readdata;

    logic             mem_wr;
    logic [AW-1:0]    mem_addr;
    logic [Dbits-1:0] mem_writedata;
    logic [Dbits-1:0] mem_readdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_writedata,
        output cpu_ack, cpu_readdata,
        input  eng_req, eng_wr, eng_addr, eng_writedata,
        output eng_ack, eng_readdata,
        output mem_wr, mem_addr, mem_writedata,
        input  mem_readdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_writedata,
        input  cpu_ack, cpu_readdata,
        output eng_req, eng_wr, eng_addr, eng_writedata,
        input  eng_ack, eng_readdata,
        input  mem_wr, mem_addr, mem_writedata,
        output mem_readdata
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Combinational 2-way grant picker.
//   i_reqs       : request vector, bit 0 = CPU, bit 1 = engine
//   i_last_grant : requester granted most recently
//   o_gnt_vld    : at least one requester is asking
//   o_gnt_id     : chosen requester
// Default: round-robin on ties (the port not granted last wins).
// Build option DMEM_ARB_FIXED_PRIO_EN: CPU always wins ties; i_last_grant is
// then ignored.
// -----------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [NREQ-1:0] i_reqs,
    input  req_id_t         i_last_grant,
    output logic            o_gnt_vld,
    output req_id_t         o_gnt_id
);

    logic w_cpu;
    logic w_eng;

    assign w_cpu = i_reqs[0];
    assign w_eng = i_reqs[1];

    always_comb begin
        o_gnt_vld = w_cpu | w_eng;
        o_gnt_id  = REQ_CPU;
        if (w_eng && !w_cpu) begin
            o_gnt_id = REQ_ENG;
        end else if (w_eng && w_cpu) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            o_gnt_id = REQ_CPU;
`else
            o_gnt_id = (i_last_grant == REQ_CPU) ? REQ_ENG : REQ_CPU;
`endif
        end
    end

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // History is still tracked by the caller but has no say in this build.
    logic w_unused_last;
    assign w_unused_last = (i_last_grant == REQ_ENG);
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the CPU (port 0) and the maze
// engine (port 1). A request seen in IDLE is latched and presented to dmem for
// exactly one ACCESS cycle, during which the winner's ack is high and its
// readdata carries the asynchronous memory read. Peak rate: one access every
// two cycles.
// Parameters: Nloc (memory depth), Dbits (data width).
// Ports:
//   clock  : system clock, all state on posedge
//   reset  : synchronous, active-high
//   io_bus : dmem_arb_if.slave (requester handshakes and dmem bus)
// Build option DMEM_ARB_FIXED_PRIO_EN (in dmem_arb_pick): fixed CPU priority
// instead of round-robin.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int Nloc  = 64,
    parameter int Dbits = 32
) (
    input  logic       clock,
    input  logic       reset,
    dmem_arb_if.slave  io_bus
);

    localparam int AW = $clog2(Nloc);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_wr;
    logic             w_wr_nxt;
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    w_addr_nxt;
    logic [Dbits-1:0] r_wdata;
    logic [Dbits-1:0] w_wdata_nxt;
    req_id_t          r_id;
    req_id_t          w_id_nxt;
    req_id_t          r_last_grant;
    req_id_t          w_last_nxt;

    logic [NREQ-1:0]  w_reqs;
    logic             w_gnt_vld;
    req_id_t          w_gnt_id;
    logic             w_access;

    assign w_reqs = {io_bus.eng_req, io_bus.cpu_req};

    dmem_arb_pick u_pick (
        .i_reqs       (w_reqs),
        .i_last_grant (r_last_grant),
        .o_gnt_vld    (w_gnt_vld),
        .o_gnt_id     (w_gnt_id)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_id_nxt    = r_id;
        w_last_nxt  = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_state_nxt = ST_ACCESS;
                    w_id_nxt    = w_gnt_id;
                    w_last_nxt  = w_gnt_id;
                    if (w_gnt_id == REQ_ENG) begin
                        w_wr_nxt    = io_bus.eng_wr;
                        w_addr_nxt  = io_bus.eng_addr;
                        w_wdata_nxt = io_bus.eng_writedata;
                    end else begin
                        w_wr_nxt    = io_bus.cpu_wr;
                        w_addr_nxt  = io_bus.cpu_addr;
                        w_wdata_nxt = io_bus.cpu_writedata;
                    end
                end
            end
            ST_ACCESS: begin
                // Requests are never chained here: the held req is re-arbitrated
                // in the following IDLE cycle.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_id         <= REQ_CPU;
            r_last_grant <= REQ_ENG;   // CPU wins the first tie after reset
        end else begin
            r_state      <= w_state_nxt;
            r_wr         <= w_wr_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_id         <= w_id_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    // Reset gates the access so a write in flight cannot commit on the edge
    // where reset is sampled. Apart from reset, everything below is decoded
    // from registers only.
    assign w_access = (r_state == ST_ACCESS) && !reset;

    assign io_bus.mem_wr        = w_access && r_wr;
    assign io_bus.mem_addr      = w_access ? r_addr  : '0;
    assign io_bus.mem_writedata = w_access ? r_wdata : '0;
    assign io_bus.cpu_ack       = w_access && (r_id == REQ_CPU);
    assign io_bus.eng_ack       = w_access && (r_id == REQ_ENG);

    // Read data is zeroed outside the owner's ack cycle so nothing leaks.
    assign io_bus.cpu_readdata  = io_bus.cpu_ack ? io_bus.mem_readdata : '0;
    assign io_bus.eng_readdata  = io_bus.eng_ack ? io_bus.mem_readdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Bench for dmem_arbiter with a behavioural dmem (asynchronous read, write on
// posedge when mem_wr). Directed table, hand sequences for multi-cycle corners,
// then random legal traffic against a transaction-level reference model.
// Compile with +define+DMEM_ARB_FIXED_PRIO_EN to check the fixed-priority build.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clock;
    logic reset;

    dmem_arb_if #(.Nloc(64), .Dbits(32)) bus ();

    dmem_arbiter #(.Nloc(64), .Dbits(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural dmem plus a backdoor port used only for preloading.
    logic [31:0] mem [0:63];
    logic        bd_we;
    logic [5:0]  bd_addr;
    logic [31:0] bd_data;

    assign bus.mem_readdata = mem[bus.mem_addr];

    always @(posedge clock) begin
        if (bus.mem_wr)
            mem[bus.mem_addr] <= bus.mem_writedata;
        else if (bd_we)
            mem[bd_addr] <= bd_data;
    end

    logic [31:0] ref_mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_writedata = '0;
        bus.eng_req = 1'b0; bus.eng_wr = 1'b0; bus.eng_addr = '0; bus.eng_writedata = '0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_mem_wr"},   32'(bus.mem_wr), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wd"},   bus.mem_writedata, 32'd0);
        chk({tag, "_cpu_ack"},  32'(bus.cpu_ack), 32'd0);
        chk({tag, "_eng_ack"},  32'(bus.eng_ack), 32'd0);
        chk({tag, "_cpu_rd"},   bus.cpu_readdata, 32'd0);
        chk({tag, "_eng_rd"},   bus.eng_readdata, 32'd0);
    endtask

    typedef struct {
        logic        port;       // 0 = CPU, 1 = engine
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        exp_cpu_ack;
        logic        exp_eng_ack;
        logic        exp_mem_wr;
        logic [31:0] exp_rdata;  // memory content seen during the ack cycle
    } tvec_t;

    tvec_t tv [7];

    // Random-phase requester state and reference model.
    logic        r_req   [2];
    logic        r_wr    [2];
    logic [5:0]  r_addr  [2];
    logic [31:0] r_wd    [2];
    logic        p_req   [2];
    logic        p_wr    [2];
    logic [5:0]  p_addr  [2];
    logic [31:0] p_wd    [2];
    logic        ack_cur [2];
    logic        ack_prev[2];
    bit          m_busy;
    int          m_last;

    task automatic apply_rand();
        bus.cpu_req = r_req[0]; bus.cpu_wr = r_wr[0]; bus.cpu_addr = r_addr[0]; bus.cpu_writedata = r_wd[0];
        bus.eng_req = r_req[1]; bus.eng_wr = r_wr[1]; bus.eng_addr = r_addr[1]; bus.eng_writedata = r_wd[1];
        for (int p = 0; p < 2; p++) begin
            p_req[p] = r_req[p]; p_wr[p] = r_wr[p]; p_addr[p] = r_addr[p]; p_wd[p] = r_wd[p];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] val;
        bit fixed_prio;
        fixed_prio = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        fixed_prio = 1'b1;
`endif
        reset = 1'b1;
        drive_idle();
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;

        // Preload memory while the arbiter is held in reset.
        for (int i = 0; i < 64; i++) begin
            val = 32'h1000_0000 + 32'(i);
            if (i == 5)  val = 32'hDEADBEEF;
            if (i == 20) val = 32'h5555_AAAA;
            ref_mem[i] = val;
            bd_we = 1'b1; bd_addr = 6'(i); bd_data = val;
            tick();
        end
        bd_we = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check_idle("reset_state");

        // ---------------- directed table ----------------
        tv[0] = '{1'b0, 1'b0, 6'd5,  32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tv[1] = '{1'b1, 1'b1, 6'd12, 32'h0000_00A5, 1'b0, 1'b1, 1'b1, 32'h1000_000C};
        tv[2] = '{1'b0, 1'b0, 6'd12, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_00A5};
        tv[3] = '{1'b0, 1'b1, 6'd63, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 32'h1000_003F};
        tv[4] = '{1'b1, 1'b0, 6'd63, 32'h0,        1'b0, 1'b1, 1'b0, 32'hCAFE_F00D};
        tv[5] = '{1'b1, 1'b0, 6'd5,  32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        tv[6] = '{1'b0, 1'b0, 6'd0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h1000_0000};

        for (int i = 0; i < 7; i++) begin
            drive_idle();
            if (tv[i].port == 1'b0) begin
                bus.cpu_req = 1'b1; bus.cpu_wr = tv[i].wr;
                bus.cpu_addr = tv[i].addr; bus.cpu_writedata = tv[i].wdata;
            end else begin
                bus.eng_req = 1'b1; bus.eng_wr = tv[i].wr;
                bus.eng_addr = tv[i].addr; bus.eng_writedata = tv[i].wdata;
            end
            tick();
            chk($sformatf("tv%0d_cpu_ack", i), 32'(bus.cpu_ack), 32'(tv[i].exp_cpu_ack));
            chk($sformatf("tv%0d_eng_ack", i), 32'(bus.eng_ack), 32'(tv[i].exp_eng_ack));
            chk($sformatf("tv%0d_mem_wr", i),  32'(bus.mem_wr),  32'(tv[i].exp_mem_wr));
            chk($sformatf("tv%0d_mem_addr", i), 32'(bus.mem_addr), 32'(tv[i].addr));
            chk($sformatf("tv%0d_mem_wd", i),  bus.mem_writedata, tv[i].wdata);
            chk($sformatf("tv%0d_cpu_rd", i),  bus.cpu_readdata, tv[i].exp_cpu_ack ? tv[i].exp_rdata : 32'd0);
            chk($sformatf("tv%0d_eng_rd", i),  bus.eng_readdata, tv[i].exp_eng_ack ? tv[i].exp_rdata : 32'd0);
            if (tv[i].wr) ref_mem[tv[i].addr] = tv[i].wdata;
            drive_idle();
            tick();
            check_idle($sformatf("tv%0d_after", i));
        end

        // ---------------- simultaneous held requests ----------------
        reset = 1'b1; tick(); reset = 1'b0;
        drive_idle();
        bus.cpu_req = 1'b1; bus.cpu_addr = 6'd1;
        bus.eng_req = 1'b1; bus.eng_addr = 6'd2;
        for (int c = 1; c <= 8; c++) begin
            logic e_cpu, e_eng;
            tick();
            e_cpu = (c % 2 == 1) && (fixed_prio || (c % 4 == 1));
            e_eng = (c % 2 == 1) && !fixed_prio && (c % 4 == 3);
            chk($sformatf("sim_c%0d_cpu_ack", c), 32'(bus.cpu_ack), 32'(e_cpu));
            chk($sformatf("sim_c%0d_eng_ack", c), 32'(bus.eng_ack), 32'(e_eng));
            chk($sformatf("sim_c%0d_excl", c), 32'(bus.cpu_ack & bus.eng_ack), 32'd0);
            chk($sformatf("sim_c%0d_cpu_rd", c), bus.cpu_readdata, e_cpu ? ref_mem[1] : 32'd0);
            chk($sformatf("sim_c%0d_eng_rd", c), bus.eng_readdata, e_eng ? ref_mem[2] : 32'd0);
        end
        bus.cpu_req = 1'b0;
        tick();
        chk("sim_c9_eng_ack", 32'(bus.eng_ack), 32'd1);
        chk("sim_c9_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        drive_idle();
        tick();

        // ---------------- idle for 10 cycles ----------------
        for (int c = 0; c < 10; c++) begin
            tick();
            check_idle($sformatf("idle%0d", c));
        end

        // ---------------- reset during an engine write ----------------
        bus.eng_req = 1'b1; bus.eng_wr = 1'b1; bus.eng_addr = 6'd20; bus.eng_writedata = 32'h0000_1234;
        tick();
        chk("rst_pre_eng_ack", 32'(bus.eng_ack), 32'd1);
        chk("rst_pre_mem_wr",  32'(bus.mem_wr), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mem_wr",  32'(bus.mem_wr), 32'd0);
        chk("rst_eng_ack", 32'(bus.eng_ack), 32'd0);
        drive_idle();
        tick();
        chk("rst_mem20", mem[20], 32'h5555_AAAA);
        reset = 1'b0;
        #1;
        check_idle("rst_after");
        bus.cpu_req = 1'b1; bus.cpu_addr = 6'd3;
        bus.eng_req = 1'b1; bus.eng_addr = 6'd4;
        tick();
        chk("rst_tie_cpu_ack", 32'(bus.cpu_ack), 32'd1);
        chk("rst_tie_eng_ack", 32'(bus.eng_ack), 32'd0);
        bus.cpu_req = 1'b0;
        tick();
        chk("rst_gap_eng_ack", 32'(bus.eng_ack), 32'd0);
        tick();
        chk("rst_next_eng_ack", 32'(bus.eng_ack), 32'd1);
        chk("rst_next_eng_rd", bus.eng_readdata, ref_mem[4]);
        drive_idle();

        // ---------------- random traffic vs reference model ----------------
        reset = 1'b1; tick(); reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0; r_wr[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0;
            ack_cur[p] = 1'b0; ack_prev[p] = 1'b0;
        end
        m_busy = 1'b0;
        m_last = 1;   // engine counts as granted last after reset
        apply_rand();
        for (int n = 0; n < 400; n++) begin
            bit exp_acc;
            int exp_id;
            logic [31:0] exp_rd;
            tick();
            // An access needs a free cycle before it; ties go to the other port
            // than the previous winner (or always the CPU in the fixed build).
            exp_acc = 1'b0; exp_id = 0;
            if (!m_busy && (p_req[0] || p_req[1])) begin
                exp_acc = 1'b1;
                if (p_req[0] && p_req[1]) exp_id = fixed_prio ? 0 : 1 - m_last;
                else                      exp_id = p_req[1] ? 1 : 0;
            end
            m_busy = exp_acc;
            if (exp_acc) m_last = exp_id;
            exp_rd = exp_acc ? ref_mem[p_addr[exp_id]] : 32'd0;
            chk("rnd_cpu_ack", 32'(bus.cpu_ack), 32'(exp_acc && exp_id == 0));
            chk("rnd_eng_ack", 32'(bus.eng_ack), 32'(exp_acc && exp_id == 1));
            chk("rnd_mem_wr",  32'(bus.mem_wr), 32'(exp_acc && p_wr[exp_id]));
            chk("rnd_mem_addr", 32'(bus.mem_addr), exp_acc ? 32'(p_addr[exp_id]) : 32'd0);
            chk("rnd_mem_wd",  bus.mem_writedata, exp_acc ? p_wd[exp_id] : 32'd0);
            chk("rnd_cpu_rd",  bus.cpu_readdata, (exp_acc && exp_id == 0) ? exp_rd : 32'd0);
            chk("rnd_eng_rd",  bus.eng_readdata, (exp_acc && exp_id == 1) ? exp_rd : 32'd0);
            if (exp_acc && p_wr[exp_id]) ref_mem[p_addr[exp_id]] = p_wd[exp_id];

            for (int p = 0; p < 2; p++) begin
                ack_prev[p] = ack_cur[p];
                ack_cur[p]  = exp_acc && (exp_id == p);
                if (ack_cur[p]) begin
                    // request held through its ack cycle
                end else if (ack_prev[p] || !r_req[p]) begin
                    r_req[p] = ($urandom_range(0, 99) < 55);
                    if (r_req[p]) begin
                        r_wr[p]   = $urandom_range(0, 1) == 1;
                        r_addr[p] = 6'($urandom_range(0, 7));
                        r_wd[p]   = $urandom;
                    end
                end
            end
            apply_rand();
        end
        drive_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
